// File: rtl/image_pkg.sv
// Shared types and constants for the image cross-fade controller.
// Holds image index width, default blend width and FSM encoding.
package image_pkg;
  localparam int IMG_IDX_W   = 2;
  localparam int ALPHA_W_DEF = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FADE = 1'b1;
endpackage

// File: rtl/image_fade_ctrl_if.sv
// Image select / fade status bundle between a requester and the fader.
// master drives the request side; slave is the fade controller.
interface image_fade_ctrl_if
  import image_pkg::*;
#(
  parameter int ALPHA_W = ALPHA_W_DEF
) ();
  logic [IMG_IDX_W-1:0] image_index;
  logic                 frame_start;
  logic [IMG_IDX_W-1:0] cur_image;
  logic [IMG_IDX_W-1:0] next_image;
  logic [ALPHA_W-1:0]   alpha;
  logic                 busy;
  logic                 swap_done;

  modport master (
    output image_index, frame_start,
    input  cur_image, next_image, alpha, busy, swap_done
  );

  modport slave (
    input  image_index, frame_start,
    output cur_image, next_image, alpha, busy, swap_done
  );
endinterface

// File: rtl/frame_step_div.sv
// Divides frame_start ticks into alpha steps of FRAMES_PER_STEP frames.
// step is high on the tick that completes a group.
module frame_step_div #(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic tick,
  output logic step
);
  localparam logic [7:0] LAST = 8'(FRAMES_PER_STEP - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
    end
  end

  assign step = tick & ~clr & (cnt == LAST);
endmodule

// File: rtl/image_fade_ctrl.sv
// Two-state cross-fade controller between displayed images.
// IMAGE_FADE_EN enables alpha ramping; otherwise swaps on one frame.
module image_fade_ctrl
  import image_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2,
  parameter int ALPHA_W         = ALPHA_W_DEF
) (
  input logic              clk,
  input logic              reset_n,
  image_fade_ctrl_if.slave io
);
  if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 255) begin : g_bad_fps
    $error("FRAMES_PER_STEP must be 1..255");
  end

  logic [0:0]           state;
  logic [IMG_IDX_W-1:0] cur;
  logic [IMG_IDX_W-1:0] nxt;
  logic                 busy;
  logic                 done;
  logic                 step;
  logic                 last;

`ifdef IMAGE_FADE_EN
  localparam int DIV = FRAMES_PER_STEP;
  localparam logic [ALPHA_W-1:0] ALPHA_MAX = '1;

  logic [ALPHA_W-1:0] alpha_q;

  assign last = (alpha_q == ALPHA_MAX);

  always_ff @(posedge clk) begin
    if (!reset_n || state == IDLE || (step && last)) begin
      alpha_q <= '0;
    end else if (step) begin
      alpha_q <= alpha_q + 1'b1;
    end
  end

  assign io.alpha = alpha_q;
`else
  localparam int DIV = 1;

  assign last     = 1'b1;
  assign io.alpha = '0;
`endif

  // Cleared while idle so the entry-cycle frame_start is never counted
  frame_step_div #(
    .FRAMES_PER_STEP(DIV)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (state == IDLE),
    .tick   (io.frame_start),
    .step   (step)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cur   <= '0;
      nxt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        state == IDLE: begin
          if (io.image_index != cur) begin
            nxt   <= io.image_index;
            busy  <= 1'b1;
            state <= FADE;
          end
        end
        state == FADE: begin
          if (step && last) begin
            cur   <= nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign io.cur_image  = cur;
  assign io.next_image = nxt;
  assign io.busy       = busy;
  assign io.swap_done  = done;
endmodule

// File: tb/tb_image_fade_ctrl.sv
// Randomised bench for image_fade_ctrl against a frame-count model.
// Directed scenarios first, then random requests, frames and resets.
module tb_image_fade_ctrl;
  localparam int FPS = 2;
  localparam int AW  = 4;
`ifdef IMAGE_FADE_EN
  localparam int TOTAL = ((1 << AW)) * FPS;
  localparam int PRE   = 14;
`else
  localparam int TOTAL = 1;
  localparam int PRE   = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  bit   chk_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  image_fade_ctrl_if #(.ALPHA_W(AW)) io ();

  image_fade_ctrl #(
    .FRAMES_PER_STEP(FPS),
    .ALPHA_W        (AW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io     (io)
  );

  always #5 clk = ~clk;

  // Model: a transition is a count of frame pulses since entry
  int m_cur, m_next, m_pulses;
  bit m_busy, m_done;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_cur = 0; m_next = 0; m_pulses = 0;
      m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (int'(io.image_index) != m_cur) begin
          m_next = int'(io.image_index);
          m_busy = 1;
          m_pulses = 0;
        end
      end else if (io.frame_start) begin
        m_pulses++;
        if (m_pulses == TOTAL) begin
          m_cur = m_next;
          m_busy = 0;
          m_done = 1;
          m_pulses = 0;
        end
      end
    end
  end

  function automatic int exp_alpha();
`ifdef IMAGE_FADE_EN
    return m_busy ? m_pulses / FPS : 0;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int en;
      int ea;
      en = m_busy ? m_next : m_cur;
      ea = exp_alpha();
      vectors++;
      if (int'(io.cur_image) != m_cur || int'(io.next_image) != en ||
          int'(io.alpha) != ea || io.busy != m_busy ||
          io.swap_done != m_done) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t got cur=%0d nxt=%0d a=%0d b=%0d d=%0d want cur=%0d nxt=%0d a=%0d b=%0d d=%0d",
                 $time, io.cur_image, io.next_image, io.alpha, io.busy,
                 io.swap_done, m_cur, en, ea, m_busy, m_done);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic fs);
    io.frame_start = fs;
    @(posedge clk);
    #1;
    io.frame_start = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  initial begin
    io.image_index = 2'd0;
    io.frame_start = 1'b0;
    reset_n = 1'b0;
    repeat (2) cyc(1'b0);
    chk_en = 1'b1;
    check("rst_cur", int'(io.cur_image), 0);
    check("rst_next", int'(io.next_image), 0);
    check("rst_alpha", int'(io.alpha), 0);
    check("rst_busy", int'(io.busy), 0);
    check("rst_done", int'(io.swap_done), 0);
    reset_n = 1'b1;

    pulses(10);
    check("idle_cur", int'(io.cur_image), 0);
    check("idle_busy", int'(io.busy), 0);

    // Entry with a coincident frame pulse that must not count
    io.image_index = 2'd3;
    cyc(1'b1);
    check("entry_busy", int'(io.busy), 1);
    check("entry_next", int'(io.next_image), 3);
    check("entry_alpha", int'(io.alpha), 0);
    cyc(1'b0);
    pulses(TOTAL - 1);
    check("pre_swap_busy", int'(io.busy), 1);
    check("pre_swap_cur", int'(io.cur_image), 0);
    cyc(1'b1);
    check("swap_done", int'(io.swap_done), 1);
    check("swap_cur", int'(io.cur_image), 3);
    check("swap_alpha", int'(io.alpha), 0);
    check("swap_busy", int'(io.busy), 0);
    cyc(1'b0);
    check("swap_pulse_len", int'(io.swap_done), 0);

    // Request change mid-fade is ignored, then re-fades
    io.image_index = 2'd1;
    cyc(1'b0);
    check("fade1_busy", int'(io.busy), 1);
    io.image_index = 2'd2;
    pulses(TOTAL - 1);
    cyc(1'b1);
    check("fade1_done", int'(io.swap_done), 1);
    check("fade1_cur", int'(io.cur_image), 1);
    cyc(1'b0);
    check("refade_busy", int'(io.busy), 1);
    check("refade_next", int'(io.next_image), 2);
    pulses(TOTAL);
    check("refade_cur", int'(io.cur_image), 2);

    // Reset mid-fade abandons the transition
    io.image_index = 2'd3;
    cyc(1'b0);
    pulses(PRE);
    check("mid_alpha", int'(io.alpha), PRE / FPS);
    reset_n = 1'b0;
    cyc(1'b0);
    check("mrst_cur", int'(io.cur_image), 0);
    check("mrst_alpha", int'(io.alpha), 0);
    check("mrst_busy", int'(io.busy), 0);
    check("mrst_done", int'(io.swap_done), 0);
    reset_n = 1'b1;
    cyc(1'b0);
    check("restart_busy", int'(io.busy), 1);
    check("restart_next", int'(io.next_image), 3);
    pulses(TOTAL);
    check("restart_cur", int'(io.cur_image), 3);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0)
        io.image_index = 2'($urandom_range(0, 3));
      reset_n = ($urandom_range(0, 299) != 0);
      cyc($urandom_range(0, 2) == 0);
    end
    reset_n = 1'b1;
    repeat (4) cyc(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end
endmodule

// File: doc/image_fade_ctrl.md
IMAGE_FADE_CTRL -- requirements
Module: image_fade_ctrl

Interface
REQ-001 Parameter FRAMES_PER_STEP, default 2, is the number of frame_start pulses per alpha step (legal range 1..255).
REQ-002 Parameter ALPHA_W, default 4, is the blend-weight width; ALPHA_MAX = 2^ALPHA_W-1.
REQ-003 clk  input  1  is the single system clock; all logic is on its rising edge.
REQ-004 reset_n  input  1  is a synchronous, active-low reset.
REQ-005 image_index  input  2  is the requested image, level-held and already debounced and synchronous to clk.
REQ-006 frame_start  input  1  is a one-cycle pulse at the start of each display frame.
REQ-007 cur_image  output  2  is the image currently shown at full weight.
REQ-008 next_image  output  2  is the image being faded in; it equals cur_image when idle.
REQ-009 alpha  output  ALPHA_W  is the weight of next_image (0 = all cur_image).
REQ-010 busy  output  1  is high while a transition is in progress.
REQ-011 swap_done  output  1  is a one-cycle pulse when a transition completes.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and FADE, registered, with no combinational paths from inputs to outputs.
REQ-013 In IDLE with image_index != cur_image, the next edge SHALL: capture next_image<=image_index, clear the frame counter, set alpha to 0, set busy=1, and enter FADE.
REQ-014 In IDLE with image_index == cur_image, frame_start SHALL be ignored and all outputs held.
REQ-015 In FADE, each frame_start SHALL increment the frame counter; at count FRAMES_PER_STEP-1 the counter SHALL clear and alpha SHALL increment by 1.
REQ-016 A step at alpha == ALPHA_MAX SHALL instead complete: cur_image<=next_image, alpha<=0, busy<=0, swap_done pulses 1 cycle, return to IDLE.
REQ-017 A full transition SHALL take exactly (ALPHA_MAX+1)*FRAMES_PER_STEP frame_start pulses after entering FADE.
REQ-018 image_index changes during FADE SHALL be ignored; the transition always completes to the captured next_image.
REQ-019 After completion, IDLE SHALL re-compare on the following cycle; a differing image_index (including a return to the old image) SHALL start a new FADE one cycle after swap_done.
REQ-020 frame_start asserted on the same cycle the FSM enters FADE SHALL NOT be counted.
REQ-021 alpha SHALL never wrap or exceed ALPHA_MAX, and the frame counter SHALL never exceed FRAMES_PER_STEP-1.

Reset
REQ-022 When reset_n==0 at a clock edge, the block SHALL set: state IDLE, cur_image=0, next_image=0, alpha=0, busy=0, swap_done=0, frame counter=0.
REQ-023 Reset asserted mid-FADE SHALL abandon the transition with no swap_done pulse.
REQ-024 If image_index!=0 at reset release, a FADE SHALL start on the first cycle after release.

Configuration
REQ-025 With macro IMAGE_FADE_EN defined, the block SHALL behave per REQ-012..021.
REQ-026 Without IMAGE_FADE_EN:
  - alpha SHALL be tied to 0.
  - FADE SHALL complete on the first counted frame_start, swapping at a frame boundary.
  - swap_done and busy SHALL behave otherwise identically.

Structure
REQ-027 The shared package image_pkg SHALL hold IMG_IDX_W=2, the ALPHA_W default, and the IDLE/FADE state encoding.
REQ-028 The frame counter SHALL be a sub-module named frame_step_div, with inputs clk, reset_n, clr and tick, and a one-cycle output step.

Verification (FRAMES_PER_STEP=2, ALPHA_W=4)
REQ-029 Reset with image_index=0, then 10 frame_start pulses -> cur_image=0, alpha=0, busy=0, no swap_done.
REQ-030 image_index 0->1, then 32 frame_start pulses:
  - busy=1 one cycle after the change.
  - alpha steps 1..15 every 2nd pulse.
  - swap_done pulses on the 32nd pulse; cur_image=1, alpha=0.
REQ-031 image_index 1->2 during FADE toward 1 -> completes to cur_image=1, then a new FADE to 2 starts the cycle after swap_done.
REQ-032 reset_n low for 1 cycle at alpha=7 -> all outputs 0 next cycle, no swap_done; image_index=3 held -> FADE restarts after release.
REQ-033 IMAGE_FADE_EN undefined, image_index 0->3 -> alpha stays 0, swap_done on the 1st frame_start, cur_image=3.
REQ-034 frame_start coincident with FADE entry -> not counted; swap_done on the 32nd subsequent pulse.
